// File: rtl/i2c_line_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : i2c_line_conditioner
// Brief    : SCL/SDA pad front end. Synchronizes and deglitches both lines,
//            emits registered SCL edge / START / STOP pulses, tracks bus-busy
//            and flags an SCL-stuck-low timeout while the bus is busy.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_line_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int TIMEOUT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic timeout
);

  localparam int                   CNT_W      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0]     c_FILT_MAX = CNT_W'(FILT_LEN - 1);
  // One below the terminal count: the timeout flop is set on the edge where
  // the counter steps onto all-ones, so the pulse coincides with that value.
  localparam logic [TIMEOUT_W-1:0] c_TO_PRE   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  // Line index 0 is SCL, index 1 is SDA.
  logic [1:0] w_raw;
  logic [1:0] w_s;      // synchronized sample
  logic [1:0] w_lvl;    // current filtered level
  logic [1:0] w_flip;   // filtered level flips on the coming edge

  assign w_raw = {sda_in, scl_in};

  for (genvar g = 0; g < 2; g++) begin : g_line
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_lvl;

    // Synchronizer chain, idles high like the bus.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '1;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
    end

    assign w_s[g]    = r_sync[SYNC_STAGES-1];
    assign w_flip[g] = (w_s[g] != r_lvl) && (r_cnt == c_FILT_MAX);
    assign w_lvl[g]  = r_lvl;

    // Glitch filter: a level change must persist FILT_LEN samples to be taken.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b1;
      end else if (w_s[g] == r_lvl) begin
        r_cnt <= '0;
      end else if (w_flip[g]) begin
        r_lvl <= ~r_lvl;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1'b1);
      end
    end
  end

  logic                 w_scl_flip;
  logic                 w_sda_flip;
  logic                 w_start;
  logic                 w_stop;
  logic                 w_to_pre;
  logic                 r_scl_rise;
  logic                 r_scl_fall;
  logic                 r_start;
  logic                 r_stop;
  logic                 r_timeout;
  logic                 r_busy;
  logic [TIMEOUT_W-1:0] r_to_cnt;

  assign w_scl_flip = w_flip[0];
  assign w_sda_flip = w_flip[1];
  // SDA events only count with SCL steadily high; a simultaneous SCL flip
  // is reported as an SCL edge alone.
  assign w_start    = w_sda_flip &  w_lvl[1] & w_lvl[0] & ~w_scl_flip;
  assign w_stop     = w_sda_flip & ~w_lvl[1] & w_lvl[0] & ~w_scl_flip;
  assign w_to_pre   = r_busy & ~w_lvl[0] & (r_to_cnt == c_TO_PRE);

  // Event pulses, registered so they line up with the new filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_scl_rise <= w_scl_flip & ~w_lvl[0];
      r_scl_fall <= w_scl_flip &  w_lvl[0];
      r_start    <= w_start;
      r_stop     <= w_stop;
      r_timeout  <= w_to_pre;
    end
  end

  // Bus-busy tracking and SCL-low timeout counter; busy drops the cycle
  // after the timeout pulse, START wins over any concurrent clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      if (w_start)                r_busy <= 1'b1;
      else if (w_stop || r_timeout) r_busy <= 1'b0;

      if (!r_busy || w_lvl[0] || r_timeout) r_to_cnt <= '0;
      else                                  r_to_cnt <= r_to_cnt + TIMEOUT_W'(1'b1);
    end
  end

  assign scl_f     = w_lvl[0];
  assign sda_f     = w_lvl[1];
  assign scl_rise  = r_scl_rise;
  assign scl_fall  = r_scl_fall;
  assign start_det = r_start;
  assign stop_det  = r_stop;
  assign bus_busy  = r_busy;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_i2c_line_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_line_conditioner
// Brief    : Self-checking bench: table of line vectors with expected levels
//            and events, an event scoreboard, plus timeout and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_line_conditioner;

  localparam int LAT = 5;  // sync stages + filter length at defaults

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic scl_in = 1'b1;
  logic sda_in = 1'b1;

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout;
  logic t_scl_f, t_sda_f, t_scl_rise, t_scl_fall, t_start_det, t_stop_det, t_bus_busy, t_timeout;

  always #5 clk = ~clk;

  i2c_line_conditioner u_dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy), .timeout(timeout)
  );

  i2c_line_conditioner #(.TIMEOUT_W(4)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .scl_f(t_scl_f), .sda_f(t_sda_f), .scl_rise(t_scl_rise), .scl_fall(t_scl_fall),
    .start_det(t_start_det), .stop_det(t_stop_det), .bus_busy(t_bus_busy), .timeout(t_timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit scl; bit sda; int hold;
    bit e_rise; bit e_fall; bit e_start; bit e_stop;
    bit f_scl; bit f_sda; bit f_busy;
  } vec_t;

  typedef struct { int kind; int due; } ev_t;  // 0 rise 1 fall 2 start 3 stop 4 timeout

  vec_t vt[$];
  ev_t  q[$];
  bit   mon_en = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Match an observed pulse against the scoreboard.
  task automatic match(input int kind);
    int idx;
    idx = -1;
    for (int i = 0; i < q.size(); i++)
      if (idx < 0 && q[i].kind == kind && q[i].due == cyc) idx = i;
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d actual=pulse required=none", kind, cyc);
    end else begin
      q.delete(idx);
    end
  endtask

  // Pulse monitor on the default-parameter DUT.
  always @(negedge clk) begin
    if (mon_en) begin
      if (scl_rise)  match(0);
      if (scl_fall)  match(1);
      if (start_det) match(2);
      if (stop_det)  match(3);
      if (timeout)   match(4);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].due < cyc) begin
          total++;
          bad++;
          $display("FAIL missing_event kind=%0d due=%0d actual=none required=pulse", q[i].kind, q[i].due);
          q.delete(i);
        end
      end
    end
  end

  function automatic void add(input bit scl, input bit sda, input int hold,
                              input bit er, input bit ef, input bit es, input bit ep,
                              input bit fs, input bit fd, input bit fb);
    vt.push_back('{scl:scl, sda:sda, hold:hold, e_rise:er, e_fall:ef, e_start:es,
                   e_stop:ep, f_scl:fs, f_sda:fd, f_busy:fb});
  endfunction

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    scl_in = v.scl;
    sda_in = v.sda;
    if (v.e_rise)  q.push_back('{kind:0, due:cyc + LAT});
    if (v.e_fall)  q.push_back('{kind:1, due:cyc + LAT});
    if (v.e_start) q.push_back('{kind:2, due:cyc + LAT});
    if (v.e_stop)  q.push_back('{kind:3, due:cyc + LAT});
    repeat (v.hold - 1) @(negedge clk);
    if (v.hold > LAT) begin
      chk1($sformatf("v%0d_scl_f", idx), scl_f, v.f_scl);
      chk1($sformatf("v%0d_sda_f", idx), sda_f, v.f_sda);
      chk1($sformatf("v%0d_busy", idx), bus_busy, v.f_busy);
    end
  endtask

  initial begin
    bit [8:0] bits;
    bit       prev;
    int       d;
    int       n_to;
    int       to_cyc;

    // ---------------- vector table ----------------
    //   scl sda hold  rise fall start stop   scl_f sda_f busy
    add(1, 1, 100, 0, 0, 0, 0, 1, 1, 0);   // idle
    add(1, 0, 10,  0, 0, 1, 0, 1, 0, 1);   // START
    add(1, 1, 10,  0, 0, 0, 1, 1, 1, 0);   // STOP
    add(1, 0, 2,   0, 0, 0, 0, 1, 1, 0);   // 2-cycle glitch
    add(1, 1, 10,  0, 0, 0, 0, 1, 1, 0);
    add(1, 0, 3,   0, 0, 1, 0, 1, 0, 1);   // 3-cycle low is accepted
    add(1, 1, 10,  0, 0, 0, 1, 1, 1, 0);
    add(1, 0, 20,  0, 0, 1, 0, 1, 0, 1);   // START before clocking
    bits = 9'b101100101;
    prev = 1'b0;
    for (int i = 0; i < 9; i++) begin
      add(0, prev,    10, 0, 1, 0, 0, 0, prev,    1);
      add(0, bits[i], 10, 0, 0, 0, 0, 0, bits[i], 1);
      add(1, bits[i], 20, 1, 0, 0, 0, 1, bits[i], 1);
      prev = bits[i];
    end
    add(0, prev, 10, 0, 1, 0, 0, 0, prev, 1);
    add(0, 1,    10, 0, 0, 0, 0, 0, 1,    1);
    add(1, 1,    20, 1, 0, 0, 0, 1, 1,    1);
    add(1, 0,    20, 0, 0, 1, 0, 1, 0,    1);  // repeated START
    add(0, 0,    10, 0, 1, 0, 0, 0, 0,    1);
    add(1, 0,    20, 1, 0, 0, 0, 1, 0,    1);
    add(1, 1,    20, 0, 0, 0, 1, 1, 1,    0);  // STOP
    add(0, 0,    10, 0, 1, 0, 0, 0, 0,    0);  // simultaneous fall
    add(1, 0,    10, 1, 0, 0, 0, 1, 0,    0);
    add(1, 1,    10, 0, 0, 0, 1, 1, 1,    0);  // STOP while idle
    add(1, 1,    10, 0, 0, 0, 0, 1, 1,    0);

    // ---------------- reset state ----------------
    rst_n  = 1'b0;
    scl_in = 1'b1;
    sda_in = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_scl_f", scl_f, 1'b1);
    chk1("rst_sda_f", sda_f, 1'b1);
    chk1("rst_busy", bus_busy, 1'b0);
    chk1("rst_pulses", scl_rise | scl_fall | start_det | stop_det | timeout, 1'b0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    foreach (vt[i]) apply(i, vt[i]);
    repeat (LAT + 2) @(negedge clk);
    chkn("scoreboard_drained", q.size(), 0);
    mon_en = 1'b0;

    // ---------------- timeout (TIMEOUT_W=4) ----------------
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    sda_in = 1'b0;
    repeat (10) @(negedge clk);
    chk1("to_busy_after_start", t_bus_busy, 1'b1);
    scl_in = 1'b0;
    d      = cyc;
    n_to   = 0;
    to_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (t_timeout) begin
        n_to++;
        to_cyc = cyc;
      end
      if (cyc == d + 20) chk1("to_busy_during_pulse", t_bus_busy, 1'b1);
      if (cyc == d + 21) chk1("to_busy_after_pulse", t_bus_busy, 1'b0);
    end
    chkn("timeout_count", n_to, 1);
    chkn("timeout_latency", to_cyc - d, 20);
    chk1("to_busy_final", t_bus_busy, 1'b0);
    chk1("wide_counter_still_busy", bus_busy, 1'b1);

    // ---------------- asynchronous reset mid-transfer ----------------
    scl_in = 1'b1;
    repeat (10) @(negedge clk);
    sda_in = 1'b1;
    repeat (10) @(negedge clk);
    sda_in = 1'b0;
    repeat (10) @(negedge clk);
    scl_in = 1'b0;
    repeat (8) @(negedge clk);
    chk1("mid_busy", bus_busy, 1'b1);
    chk1("mid_to_busy", t_bus_busy, 1'b1);
    chk1("mid_scl_f", scl_f, 1'b0);
    chk1("mid_sda_f", sda_f, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_scl_f", scl_f, 1'b1);
    chk1("async_sda_f", sda_f, 1'b1);
    chk1("async_busy", bus_busy, 1'b0);
    chk1("async_to_busy", t_bus_busy, 1'b0);
    chk1("async_to_scl_f", t_scl_f, 1'b1);
    chk1("async_pulses", scl_rise | scl_fall | start_det | stop_det | timeout |
         t_scl_rise | t_scl_fall | t_start_det | t_stop_det | t_timeout | ~t_sda_f, 1'b0);
    scl_in = 1'b1;
    sda_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk1("post_rst_busy", bus_busy, 1'b0);
    chk1("post_rst_scl_f", scl_f, 1'b1);
    chk1("post_rst_sda_f", sda_f, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_line_conditioner.md
# i2c_line_conditioner

Front end for the I2C target path. Sits between the raw SCL/SDA pads and the I2C target controller. Synchronizes both lines, rejects glitches, and provides clean levels plus single-cycle SCL edge, START and STOP events. Also tracks bus-busy state and flags a stuck-low SCL timeout, so the controller downstream runs on clean, pre-decoded events only.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (>=2)
- FILT_LEN, 3, consecutive agreeing samples needed to change a filtered level (>=1; 1 = no filtering)
- TIMEOUT_W, 16, width of the SCL-low timeout counter

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- scl_in  in  1  raw SCL pad level, asynchronous
- sda_in  in  1  raw SDA pad level, asynchronous
- scl_f  out  1  filtered SCL level
- sda_f  out  1  filtered SDA level
- scl_rise  out  1  one-cycle pulse: scl_f went 0->1
- scl_fall  out  1  one-cycle pulse: scl_f went 1->0
- start_det  out  1  one-cycle pulse: START or repeated START
- stop_det  out  1  one-cycle pulse: STOP
- bus_busy  out  1  high between START and STOP/timeout
- timeout  out  1  one-cycle pulse: SCL held low too long while busy

## Operation
- Reset (async assert, removal is synchronous to clk): synchronizer flops = 1, scl_f = sda_f = 1, filter counters = 0, bus_busy = 0, timeout counter = 0, all pulses = 0.
- Synchronizer: SYNC_STAGES flops per line, reset to 1 (idle bus).
- Filter, per line: the counter clears on any synchronized sample equal to the current filtered level. On a differing sample it increments. When a differing sample arrives with the counter at FILT_LEN-1, the filtered level flips and the counter clears. Any excursion shorter than FILT_LEN cycles is rejected.
- Edge events derive from filtered-level updates. scl_rise/scl_fall assert in the same cycle the new scl_f is visible.
- START: sda_f flips 1->0 while scl_f is 1 and scl_f does not flip on the same edge. STOP: sda_f flips 0->1 under the same condition.
- Simultaneous SCL and SDA filtered flips on one edge: report the SCL edge only; no start_det or stop_det.
- bus_busy:
  - set on start_det; a repeated START while busy pulses start_det and bus_busy stays 1.
  - cleared on stop_det or timeout.
  - STOP while idle still pulses stop_det.
- Timeout counter:
  - counts while bus_busy=1 and scl_f=0; clears when scl_f=1 or bus_busy=0.
  - on reaching 2^TIMEOUT_W-1: timeout pulses for one cycle, bus_busy clears, counter clears.
  - no further timeout until the next START.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Latency: a clean input level change sampled first at edge 1 appears on scl_f/sda_f after edge SYNC_STAGES+FILT_LEN (5 at defaults). Event pulses coincide with that update.
- Pulses are exactly one cycle wide. Minimum accepted high or low time is FILT_LEN cycles after synchronization.
- Event ordering within a cycle is not relevant: each cycle carries at most one SDA-derived event (start_det or stop_det), plus at most one SCL edge.
- Timeout pulse: the cycle the counter hits the terminal count. bus_busy reads 0 from the next cycle.
- Reset mid-transfer: all state returns to reset values immediately. A later SDA fall with SCL high is needed to become busy again.

## Test plan
- Reset then idle, both lines held 1 -> scl_f=sda_f=1, bus_busy=0, no pulses over 100 cycles.
- SCL=1; drop SDA to 0 for 10 cycles -> start_det one pulse 5 cycles after the change, bus_busy=1. Raise SDA with SCL=1 -> stop_det one pulse, bus_busy=0.
- Glitch rejection: SDA low for 2 cycles with SCL=1 -> no change on sda_f, no start_det. SDA low for 3 cycles -> start_det.
- After START, toggle SCL with 20-cycle half-periods for 9 clocks -> 9 scl_rise and 9 scl_fall pulses, no spurious start_det/stop_det when SDA changes only while SCL=0. Repeated START mid-transfer -> start_det pulses, bus_busy stays 1.
- Drive SCL and SDA low on the same clock from idle -> scl_fall only, no start_det, bus_busy stays 0.
- TIMEOUT_W=4: START, then SCL held low -> timeout pulses exactly once after 15 low cycles, bus_busy=0. Assert rst_n low mid-transfer -> all outputs return to reset values without waiting for a clock edge.
